// File: rtl/sci_xfer_ctrl.sv
// sci_xfer_ctrl: byte-stream controller for an on-chip SCI (UART) peripheral.
// Configures the SCI on START, moves bytes between user FIFOs and the SCI
// TDR/RDR registers under its interrupt levels, clears status flags after each
// transfer, counts receive errors and shuts the channel down on STOP.
//
// Ports:
//   CLK, RST_N, CE          clock, async active-low reset, clock enable
//   CFG_SMR, CFG_BRR        mode / baud values written at START
//   START, STOP             channel enable / disable pulses
//   TX_DATA, TX_PUSH        user side of the TX FIFO; TX_FULL status
//   RX_DATA, RX_POP         user side of the RX FIFO (fall-through head); RX_EMPTY
//   SCI_A/DO/DI/BA/WE/REQ   32-bit register bus to the SCI
//   SCI_TXI/RXI/ERI         SCI interrupt levels
//   BUSY, ERR_CNT           channel enabled, saturating receive-error count
//
// state  | meaning
// IDLE   | channel disabled, no bus traffic
// W_SMR  | write SMR with the captured CFG_SMR
// W_BRR  | write BRR with the captured CFG_BRR
// W_SCR  | write SCR = 30h (TE, RE on)
// RUN    | wait for STOP or an interrupt level
// W_TDR  | write TX FIFO head to TDR and pop it
// C_TDRE | write SSR = 7Eh (clear TDRE)
// R_RDR  | two-cycle read of RDR, byte pushed into the RX FIFO
// C_RDRF | write SSR = BEh (clear RDRF)
// C_ERR  | write SSR = C6h (clear ORER/FER/PER), count the error
// D_SCR  | write SCR = 00h, flush FIFOs, back to IDLE
module sci_xfer_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE,
  input  logic [7:0]  CFG_SMR,
  input  logic [7:0]  CFG_BRR,
  input  logic        START,
  input  logic        STOP,
  input  logic [7:0]  TX_DATA,
  input  logic        TX_PUSH,
  output logic        TX_FULL,
  output logic [7:0]  RX_DATA,
  input  logic        RX_POP,
  output logic        RX_EMPTY,
  output logic [31:0] SCI_A,
  output logic [31:0] SCI_DO,
  input  logic [31:0] SCI_DI,
  output logic [3:0]  SCI_BA,
  output logic        SCI_WE,
  output logic        SCI_REQ,
  input  logic        SCI_TXI,
  input  logic        SCI_RXI,
  input  logic        SCI_ERI,
  output logic        BUSY,
  output logic [7:0]  ERR_CNT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] SCI_BASE = 32'hFFFF_FE00;
  localparam logic [2:0] N_SMR = 3'd0, N_BRR = 3'd1, N_SCR = 3'd2,
                         N_TDR = 3'd3, N_SSR = 3'd4, N_RDR = 3'd5;

  typedef enum logic [3:0] {
    IDLE, W_SMR, W_BRR, W_SCR, RUN, W_TDR, C_TDRE, R_RDR, C_RDRF, C_ERR, D_SCR
  } state_t;

  state_t state, state_nx;
  logic rd_ph, stop_lat;
  logic [7:0] smr_q, brr_q, err_cnt;
  logic access, wr_en, tx_pop, rx_push, err_inc, flush;
  logic [2:0] reg_n;
  logic [7:0] wr_byte;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr, tx_rd;
  logic [AW:0]   tx_cnt;
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr, rx_rd;
  logic [AW:0]   rx_cnt;
  logic tx_full_i, tx_empty, tx_push_ok, rx_full, rx_empty_i, rx_pop_ok;

  // Count never exceeds FIFO_DEPTH = 2**AW, so the top bit alone means full.
  assign tx_full_i  = tx_cnt[AW];
  assign tx_empty   = (tx_cnt == '0);
  assign tx_push_ok = TX_PUSH && !tx_full_i;
  assign rx_full    = rx_cnt[AW];
  assign rx_empty_i = (rx_cnt == '0);
  assign rx_pop_ok  = RX_POP && !rx_empty_i;

  always_comb begin
    state_nx = state;
    access   = 1'b0;
    wr_en    = 1'b0;
    reg_n    = N_SMR;
    wr_byte  = 8'h00;
    tx_pop   = 1'b0;
    rx_push  = 1'b0;
    err_inc  = 1'b0;
    flush    = 1'b0;
    case (state)
      IDLE:   if (START) state_nx = W_SMR;
      W_SMR:  begin access = 1'b1; wr_en = 1'b1; reg_n = N_SMR; wr_byte = smr_q; state_nx = W_BRR; end
      W_BRR:  begin access = 1'b1; wr_en = 1'b1; reg_n = N_BRR; wr_byte = brr_q; state_nx = W_SCR; end
      W_SCR:  begin access = 1'b1; wr_en = 1'b1; reg_n = N_SCR; wr_byte = 8'h30; state_nx = RUN; end
      RUN: begin
        if (STOP || stop_lat)          state_nx = D_SCR;
        else if (SCI_ERI)              state_nx = C_ERR;
        else if (SCI_RXI && !rx_full)  state_nx = R_RDR;
        else if (SCI_TXI && !tx_empty) state_nx = W_TDR;
      end
      W_TDR: begin
        access = 1'b1; wr_en = 1'b1; reg_n = N_TDR; wr_byte = tx_mem[tx_rd];
        tx_pop = 1'b1; state_nx = C_TDRE;
      end
      C_TDRE: begin access = 1'b1; wr_en = 1'b1; reg_n = N_SSR; wr_byte = 8'h7E; state_nx = RUN; end
      R_RDR: begin
        access = 1'b1; reg_n = N_RDR;
        if (rd_ph) begin rx_push = 1'b1; state_nx = C_RDRF; end
      end
      C_RDRF: begin access = 1'b1; wr_en = 1'b1; reg_n = N_SSR; wr_byte = 8'hBE; state_nx = RUN; end
      C_ERR: begin
        access = 1'b1; wr_en = 1'b1; reg_n = N_SSR; wr_byte = 8'hC6;
        err_inc = 1'b1; state_nx = RUN;
      end
      D_SCR: begin
        access = 1'b1; wr_en = 1'b1; reg_n = N_SCR; wr_byte = 8'h00;
        flush = 1'b1; state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      rd_ph    <= 1'b0;
      stop_lat <= 1'b0;
      smr_q    <= 8'h00;
      brr_q    <= 8'h00;
      err_cnt  <= 8'h00;
    end else if (CE) begin
      state <= state_nx;
      rd_ph <= (state == R_RDR) && !rd_ph;
      if (state == IDLE && START) begin
        smr_q <= CFG_SMR;
        brr_q <= CFG_BRR;
      end
      // RUN always consumes a pending stop, so clearing it there is safe.
      if (state == RUN) stop_lat <= 1'b0;
      else if (STOP && state != IDLE && state != D_SCR) stop_lat <= 1'b1;
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_wr <= '0; tx_rd <= '0; tx_cnt <= '0;
      rx_wr <= '0; rx_rd <= '0; rx_cnt <= '0;
    end else if (CE) begin
      if (flush) begin
        tx_wr <= '0; tx_rd <= '0; tx_cnt <= '0;
        rx_wr <= '0; rx_rd <= '0; rx_cnt <= '0;
      end else begin
        if (tx_push_ok) tx_wr <= tx_wr + 1'b1;
        if (tx_pop)     tx_rd <= tx_rd + 1'b1;
        if (tx_push_ok && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
        else if (!tx_push_ok && tx_pop) tx_cnt <= tx_cnt - 1'b1;
        if (rx_push)   rx_wr <= rx_wr + 1'b1;
        if (rx_pop_ok) rx_rd <= rx_rd + 1'b1;
        if (rx_push && !rx_pop_ok)      rx_cnt <= rx_cnt + 1'b1;
        else if (!rx_push && rx_pop_ok) rx_cnt <= rx_cnt - 1'b1;
      end
    end
  end

  // RDR is register 5, so its byte arrives on lane 23:16.
  always_ff @(posedge CLK) begin
    if (CE && !flush && tx_push_ok) tx_mem[tx_wr] <= TX_DATA;
    if (CE && rx_push)              rx_mem[rx_wr] <= SCI_DI[23:16];
  end

  logic unused_di;
  assign unused_di = ^{SCI_DI[31:24], SCI_DI[15:0]};

  assign SCI_REQ  = access;
  assign SCI_WE   = wr_en;
  assign SCI_A    = access ? (SCI_BASE + {29'd0, reg_n}) : 32'd0;
  assign SCI_BA   = access ? (4'b1000 >> reg_n[1:0]) : 4'b0000;
  assign SCI_DO   = wr_en ? {4{wr_byte}} : 32'd0;
  assign BUSY     = (state != IDLE);
  assign ERR_CNT  = err_cnt;
  assign TX_FULL  = tx_full_i;
  assign RX_EMPTY = rx_empty_i;
  assign RX_DATA  = rx_empty_i ? 8'h00 : rx_mem[rx_rd];

endmodule

// File: doc/sci_xfer_ctrl.md
SCI_XFER_CTRL -- requirements
Module: sci_xfer_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, depth of each of the TX and RX byte FIFOs; power of 2, 2..16.
REQ-002 SHALL have ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset, asynchronous, active-low.
- CE  in  1  clock enable; all state advances only when CE=1.
- CFG_SMR  in  8  SMR value applied at START.
- CFG_BRR  in  8  BRR value applied at START.
- START  in  1  one-CE pulse that configures the SCI and enables the channel.
- STOP  in  1  one-CE pulse that disables the channel.
- TX_DATA  in  8  byte to transmit.
- TX_PUSH  in  1  push TX_DATA into the TX FIFO.
- TX_FULL  out  1  TX FIFO full.
- RX_DATA  out  8  head of the RX FIFO.
- RX_POP  in  1  pop the RX FIFO.
- RX_EMPTY  out  1  RX FIFO empty.
- SCI_A  out  32  SCI register address.
- SCI_DO  out  32  write data.
- SCI_DI  in  32  read data.
- SCI_BA  out  4  byte enables.
- SCI_WE  out  1  write strobe.
- SCI_REQ  out  1  access request.
- SCI_TXI  in  1  TDR-empty interrupt level.
- SCI_RXI  in  1  RDR-full interrupt level.
- SCI_ERI  in  1  receive-error interrupt level.
- BUSY  out  1  channel enabled.
- ERR_CNT  out  8  receive errors, saturating.

Function
REQ-003 SHALL address SCI register n (SMR=0, BRR=1, SCR=2, TDR=3, SSR=4, RDR=5) as SCI_A=32'hFFFFFE00+n.
REQ-004 SHALL place byte n on lane SCI_DO[31-8(n%4) : 24-8(n%4)], replicate it on all four lanes, and drive SCI_BA=4'b1000>>(n%4).
REQ-005 SHALL complete a write in one CE cycle: SCI_REQ=1, SCI_WE=1.
REQ-006 SHALL complete a read in two CE cycles with SCI_REQ=1 and SCI_WE=0, capturing the byte lane of SCI_DI at the end of the second cycle.
REQ-007 SHALL drive SCI_REQ=0 and SCI_WE=0 in every state not named as an access.
REQ-008 SHALL implement an FSM with states IDLE, W_SMR, W_BRR, W_SCR, RUN, W_TDR, C_TDRE, R_RDR, C_RDRF, C_ERR and D_SCR.
REQ-009 IDLE: on START -> W_SMR; START is ignored in any other state.
REQ-010 SHALL write CFG_SMR in W_SMR, then CFG_BRR in W_BRR, then 8'h30 (TE=1, RE=1, interrupt enables 0) in W_SCR, then go to RUN; BUSY=1 from W_SMR through D_SCR.
REQ-011 SHALL use, in RUN, the priority STOP > SCI_ERI > (SCI_RXI and RX FIFO not full) > (SCI_TXI and TX FIFO not empty); with no event it stays in RUN.
REQ-012 Error path: C_ERR writes SSR=8'hC6 (clears ORER/FER/PER), increments ERR_CNT saturating at 8'hFF, then -> RUN.
REQ-013 Receive path: R_RDR reads RDR and pushes the byte into the RX FIFO; C_RDRF then writes SSR=8'hBE; then -> RUN.
REQ-014 Transmit path: W_TDR writes the TX FIFO head to TDR and pops it; C_TDRE then writes SSR=8'h7E; then -> RUN.
REQ-015 STOP in RUN -> D_SCR, which writes SCR=8'h00, then -> IDLE with BUSY=0.
REQ-016 STOP outside RUN SHALL be latched and taken at the next entry to RUN.
REQ-017 The FIFOs SHALL contain no data across STOP.
REQ-018 SHALL drop TX_PUSH when TX_FULL=1 and ignore RX_POP when RX_EMPTY=1.
REQ-019 SHALL, on a simultaneous user push and FSM pop of the TX FIFO, apply both and leave the count unchanged.
REQ-020 SHALL, on a simultaneous FSM push and user pop of the RX FIFO, apply both.
REQ-021 SHALL make RX_DATA the first-word-fall-through head; its value is don't-care when RX_EMPTY=1.
REQ-022 SHALL use pointers that wrap modulo FIFO_DEPTH and counts of log2(FIFO_DEPTH)+1 bits.
REQ-023 SHALL keep the SCI interrupt inputs level-sensitive; a level still high on return to RUN is serviced again.

Reset
REQ-024 While RST_N=0, SHALL hold the FSM in IDLE with FIFOs empty, ERR_CNT=0, BUSY=0, SCI_REQ=0, SCI_WE=0, SCI_A=0, SCI_DO=0, SCI_BA=0, TX_FULL=0, RX_EMPTY=1 and RX_DATA=0.
REQ-025 SHALL abort any access in progress when reset is asserted mid-operation, with no further bus cycles until a new START.

Verification
REQ-026 START with CFG_SMR=8'h00, CFG_BRR=8'h0F -> writes at FFFFFE00 (lane 31:24, BA=1000), FFFFFE01=0F (BA=0100), FFFFFE02=30 (BA=0010); BUSY=1 after the first write.
REQ-027 In RUN, push 8'hA5 and pulse SCI_TXI -> write TDR=A5 at FFFFFE03 (BA=0001), then SSR=7E at FFFFFE04; TX FIFO empty.
REQ-028 SCI_RXI high with SCI_DI lane 23:16=8'h3C -> 2-cycle read at FFFFFE05, then SSR=BE write; RX_EMPTY=0, RX_DATA=3C.
REQ-029 SCI_ERI, SCI_RXI and SCI_TXI all high in the same cycle -> C_ERR (SSR=C6) first, ERR_CNT=1, then the RX path, then the TX path.
REQ-030 Push FIFO_DEPTH+1 bytes -> TX_FULL=1 after FIFO_DEPTH pushes, last byte dropped; 256 errors -> ERR_CNT holds FF.
REQ-031 STOP during R_RDR, then RST_N pulsed low -> after STOP: SCR=00 write then IDLE; after reset: all outputs at reset values, no SCI_REQ.
